// File: rtl/fsk_clkdiv_pkg.sv
// Purpose: shared constants, types and helpers for the FSK modulator clock divider.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package fsk_clkdiv_pkg;

  localparam int CLKDIV_CNT_W        = 8;
  localparam int CLKDIV_DEF_HALF     = 8;
  localparam int CLKDIV_LOCK_TOGGLES = 16;

  typedef logic [CLKDIV_CNT_W-1:0] half_t;

  // A zero half-period cannot be counted, so it is treated as the fastest
  // legal ratio (half = 1, i.e. f_clk/2).
  function automatic logic [31:0] clamp_half(input logic [31:0] h);
    return (h == 32'd0) ? 32'd1 : h;
  endfunction

endpackage

// File: rtl/fsk_clkdiv_channel.sv
// Purpose: one 50%-duty divider channel with glitch-free ratio switching and sticky lock.
// Latency: clk_out toggles on the cycle the counter hits half_active-1; a new ratio lands on the next 1->0 edge.
// Backpressure: pend stays high from config accept until the new ratio is applied; the parent must not write while it is high.
//
// Ports: clk, rst_n (async active-low), cfg_vld (qualified write strobe), cfg_half,
//        align (phase restart), clk_out, clk_lock, pend.
module fsk_clkdiv_channel
  import fsk_clkdiv_pkg::*;
#(
  parameter int CNT_W        = CLKDIV_CNT_W,
  parameter int DEF_HALF     = CLKDIV_DEF_HALF,
  parameter int LOCK_TOGGLES = CLKDIV_LOCK_TOGGLES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_vld,
  input  logic [CNT_W-1:0] cfg_half,
  input  logic             align,
  output logic             clk_out,
  output logic             clk_lock,
  output logic             pend
);

  localparam logic [CNT_W-1:0] HALF_RST = CNT_W'(DEF_HALF);
  localparam logic [CNT_W-1:0] LOCK_T   = CNT_W'(LOCK_TOGGLES);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] half_act_q, half_act_d;
  logic [CNT_W-1:0] half_pend_q, half_pend_d;
  logic [CNT_W-1:0] tog_q, tog_d;
  logic             pend_q, pend_d;
  logic             out_q, out_d;
  logic             lock_q, lock_d;

  logic [CNT_W-1:0] half_req;
  logic             wrap;

  always_comb begin
    half_req    = CNT_W'(clamp_half(32'(cfg_half)));
    wrap        = (cnt_q == half_act_q - CNT_W'(1));

    cnt_d       = cnt_q + CNT_W'(1);
    half_act_d  = half_act_q;
    half_pend_d = half_pend_q;
    tog_d       = tog_q;
    pend_d      = pend_q;
    out_d       = out_q;
    // Lock follows the toggle counter by one cycle and is sticky.
    lock_d      = lock_q | (tog_q == LOCK_T);

    if (align) begin
      cnt_d  = '0;
      out_d  = 1'b0;
      tog_d  = '0;
      lock_d = 1'b0;
      if (pend_q) begin
        half_act_d = half_pend_q;
        pend_d     = 1'b0;
      end
    end else if (wrap) begin
      cnt_d = '0;
      out_d = ~out_q;
      // Only swap ratios at the end of a full period (high->low) so the
      // old ratio always finishes its current cycle: no runt pulses.
      if (out_q && pend_q) begin
        half_act_d = half_pend_q;
        pend_d     = 1'b0;
        tog_d      = '0;
        lock_d     = 1'b0;
      end else if (tog_q != LOCK_T) begin
        tog_d = tog_q + CNT_W'(1);
      end
    end

    // The parent only strobes cfg_vld when pend_q is low, so this never
    // collides with an apply in the same cycle. A write of the running
    // ratio is swallowed so it does not disturb lock.
    if (cfg_vld && (half_req != half_act_q)) begin
      half_pend_d = half_req;
      pend_d      = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      half_act_q  <= HALF_RST;
      half_pend_q <= HALF_RST;
      tog_q       <= '0;
      pend_q      <= 1'b0;
      out_q       <= 1'b0;
      lock_q      <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      half_act_q  <= half_act_d;
      half_pend_q <= half_pend_d;
      tog_q       <= tog_d;
      pend_q      <= pend_d;
      out_q       <= out_d;
      lock_q      <= lock_d;
    end
  end

  assign clk_out  = out_q;
  assign clk_lock = lock_q;
  assign pend     = pend_q;

endmodule

// File: rtl/fsk_clock_divider.sv
// Purpose: N_CH runtime-programmable 50%-duty clock dividers for the FSK modulator clock path.
// Latency: outputs are registered; all_lock trails the per-channel locks by one cycle.
// Backpressure: cfg_ready = !pend of the addressed channel (1 for out-of-range channels and in reset).
//
// Ports: clk, pll_lock (async active-low reset), cfg_valid/cfg_ready/cfg_ch/cfg_half (config),
//        clk_out, clk_lock (per channel), all_lock, align_req (only with FSK_CLKDIV_PHASE_ALIGN_EN).
// Optional: define FSK_CLKDIV_PHASE_ALIGN_EN to add align_req, which restarts every channel in phase.
module fsk_clock_divider
  import fsk_clkdiv_pkg::*;
#(
  parameter  int N_CH         = 2,
  parameter  int CNT_W        = CLKDIV_CNT_W,
  parameter  int DEF_HALF     = CLKDIV_DEF_HALF,
  parameter  int LOCK_TOGGLES = CLKDIV_LOCK_TOGGLES,
  localparam int CH_W         = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk,
  input  logic             pll_lock,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [CNT_W-1:0] cfg_half,
`ifdef FSK_CLKDIV_PHASE_ALIGN_EN
  input  logic             align_req,
`endif
  output logic [N_CH-1:0]  clk_out,
  output logic [N_CH-1:0]  clk_lock,
  output logic             all_lock
);

  logic [N_CH-1:0] pend;
  logic [N_CH-1:0] ch_we;
  logic            align;
  logic            all_lock_q, all_lock_d;

`ifdef FSK_CLKDIV_PHASE_ALIGN_EN
  assign align = align_req;
`else
  assign align = 1'b0;
`endif

  // Channel numbers beyond N_CH match no channel: ready stays 1 and the
  // write is absorbed without effect.
  always_comb begin
    cfg_ready = 1'b1;
    ch_we     = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (cfg_ch == CH_W'(i)) begin
        cfg_ready = ~pend[i];
        ch_we[i]  = cfg_valid & ~pend[i];
      end
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    fsk_clkdiv_channel #(
      .CNT_W        (CNT_W),
      .DEF_HALF     (DEF_HALF),
      .LOCK_TOGGLES (LOCK_TOGGLES)
    ) u_ch (
      .clk      (clk),
      .rst_n    (pll_lock),
      .cfg_vld  (ch_we[i]),
      .cfg_half (cfg_half),
      .align    (align),
      .clk_out  (clk_out[i]),
      .clk_lock (clk_lock[i]),
      .pend     (pend[i])
    );
  end

  always_comb begin
    all_lock_d = &clk_lock;
  end

  always_ff @(posedge clk or negedge pll_lock) begin
    if (!pll_lock) begin
      all_lock_q <= 1'b0;
    end else begin
      all_lock_q <= all_lock_d;
    end
  end

  assign all_lock = all_lock_q;

endmodule

// File: tb/tb_fsk_clock_divider.sv
// Purpose: self-checking bench for fsk_clock_divider against a period-position reference model.
// Latency: outputs sampled 1 time unit after each rising clk edge; cfg_ready sampled mid-cycle.
// Backpressure: config writes are held until cfg_ready, bounded by a cycle budget.
module tb_fsk_clock_divider;

  localparam int N  = 3;
  localparam int DH = 8;
  localparam int LT = 16;

  logic       clk = 1'b0;
  logic       pll_lock;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [1:0] cfg_ch;
  logic [7:0] cfg_half;
  logic       align_req;
  logic [N-1:0] clk_out;
  logic [N-1:0] clk_lock;
  logic       all_lock;

  int total = 0;
  int bad   = 0;
  logic dut_rdy;

  always #5 clk = ~clk;

  fsk_clock_divider #(
    .N_CH         (N),
    .CNT_W        (8),
    .DEF_HALF     (DH),
    .LOCK_TOGGLES (LT)
  ) dut (
    .clk       (clk),
    .pll_lock  (pll_lock),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_half  (cfg_half),
`ifdef FSK_CLKDIV_PHASE_ALIGN_EN
    .align_req (align_req),
`endif
    .clk_out   (clk_out),
    .clk_lock  (clk_lock),
    .all_lock  (all_lock)
  );

  // Reference model: each channel tracks its position t inside the current
  // full period of length 2*h; the output is high in the second half.
  int m_h[N], m_t[N], m_hp[N], m_tog[N];
  bit m_pend[N], m_out[N], m_lock[N];
  bit m_all;

  function automatic bit m_ready(int ch);
    if (ch >= N) return 1'b1;
    return !m_pend[ch];
  endfunction

  task automatic m_reset();
    for (int i = 0; i < N; i++) begin
      m_h[i] = DH; m_t[i] = 0; m_hp[i] = DH; m_tog[i] = 0;
      m_pend[i] = 0; m_out[i] = 0; m_lock[i] = 0;
    end
    m_all = 0;
  endtask

  task automatic m_step(bit v, int ch, int half, bit al);
    bit rdy, all_nxt;
    rdy = m_ready(ch);
    all_nxt = 1'b1;
    for (int i = 0; i < N; i++) all_nxt &= m_lock[i];
    for (int i = 0; i < N; i++) begin
      bit prev, applied, hit;
      int h_old, hreq;
      h_old   = m_h[i];
      hit     = (m_tog[i] >= LT);
      applied = 1'b0;
      if (al) begin
        m_t[i] = 0; m_out[i] = 0; m_tog[i] = 0; m_lock[i] = 0;
        if (m_pend[i]) begin m_h[i] = m_hp[i]; m_pend[i] = 0; end
      end else begin
        prev = m_out[i];
        m_t[i] = m_t[i] + 1;
        if (m_t[i] == 2 * m_h[i]) begin
          m_t[i] = 0;
          if (m_pend[i]) begin m_h[i] = m_hp[i]; m_pend[i] = 0; applied = 1'b1; end
        end
        m_out[i] = (m_t[i] >= m_h[i]);
        if (applied) begin
          m_tog[i] = 0; m_lock[i] = 0;
        end else begin
          if (hit) m_lock[i] = 1'b1;
          if (m_out[i] != prev && m_tog[i] < LT) m_tog[i] = m_tog[i] + 1;
        end
      end
      if (v && rdy && ch == i) begin
        hreq = (half == 0) ? 1 : half;
        if (hreq != h_old) begin m_hp[i] = hreq; m_pend[i] = 1'b1; end
      end
    end
    m_all = all_nxt;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit al_in();
`ifdef FSK_CLKDIV_PHASE_ALIGN_EN
    return align_req;
`else
    return 1'b0;
`endif
  endfunction

  // One clock cycle: starts and ends 1 unit after a rising edge.
  task automatic cycle();
    logic [N-1:0] e_out, e_lock;
    #3;
    dut_rdy = cfg_ready;
    chk("cfg_ready", 32'(cfg_ready), 32'(m_ready(int'(cfg_ch))));
    @(posedge clk);
    if (pll_lock) m_step(cfg_valid, int'(cfg_ch), int'(cfg_half), al_in());
    #1;
    for (int i = 0; i < N; i++) begin
      e_out[i]  = m_out[i];
      e_lock[i] = m_lock[i];
    end
    chk("clk_out", 32'(clk_out), 32'(e_out));
    chk("clk_lock", 32'(clk_lock), 32'(e_lock));
    chk("all_lock", 32'(all_lock), 32'(m_all));
  endtask

  task automatic run(int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  task automatic wr(int ch, int half);
    int n;
    n = 0;
    cfg_valid = 1'b1; cfg_ch = 2'(ch); cfg_half = 8'(half);
    dut_rdy = 1'b0;
    while (!dut_rdy && n < 300) begin
      cycle();
      n++;
    end
    chk("wr_accepted", 32'(dut_rdy), 32'd1);
    cfg_valid = 1'b0;
  endtask

  task automatic first_rise(string tag);
    int n;
    n = 0;
    while (clk_out[0] !== 1'b1 && n < 50) begin
      cycle();
      n++;
    end
    chk(tag, n, DH);
  endtask

  initial begin
    pll_lock = 1'b0; cfg_valid = 1'b0; cfg_ch = '0; cfg_half = '0; align_req = 1'b0;
    m_reset();
    #1;
    chk("rst_clk_out", 32'(clk_out), 32'd0);
    chk("rst_cfg_ready", 32'(cfg_ready), 32'd1);
    run(3);

    // Defaults: period 16, first rise after 8 cycles, lock around cycle 129.
    pll_lock = 1'b1;
    first_rise("first_rise_cycles");
    run(192);
    chk("all_lock_default", 32'(all_lock), 32'd1);

    // Faster ratio on ch0 written mid-high-phase; ch1/ch2 must not move.
    while (!(clk_out[0] === 1'b1)) cycle();
    run(2);
    wr(0, 4);
    chk("pend_ready_low", 32'(cfg_ready), 32'd0);
    run(200);

    // Zero clamps to 1; equal write on a locked channel keeps lock.
    wr(0, 0);
    run(50);
    wr(1, 8);
    run(3);
    chk("ch1_lock_kept", 32'(clk_lock[1]), 32'd1);

    // Second write to a pending channel stalls; out-of-range channel is absorbed.
    wr(0, 6);
    cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_half = 8'd2;
    #1;
    chk("stall_ready_low", 32'(cfg_ready), 32'd0);
    wr(0, 2);
    wr(3, 5);
    chk("oob_ready", 32'(cfg_ready), 32'd1);
    run(60);

    // Randomized traffic.
    for (int k = 0; k < 400; k++) begin
      cfg_valid = 1'($urandom_range(0, 1));
      cfg_ch    = 2'($urandom_range(0, 3));
      cfg_half  = 8'($urandom_range(0, 9));
`ifdef FSK_CLKDIV_PHASE_ALIGN_EN
      align_req = ($urandom_range(0, 39) == 0);
`endif
      cycle();
    end
    cfg_valid = 1'b0; align_req = 1'b0;
    run(40);

    // Asynchronous reset between edges, then defaults again.
    pll_lock = 1'b0;
    m_reset();
    #1;
    chk("async_rst_out", 32'(clk_out), 32'd0);
    chk("async_rst_lock", 32'(clk_lock), 32'd0);
    chk("async_rst_all", 32'(all_lock), 32'd0);
    run(2);
    pll_lock = 1'b1;
    first_rise("first_rise_after_rst");
    run(150);

`ifdef FSK_CLKDIV_PHASE_ALIGN_EN
    wr(0, 3);
    wr(1, 5);
    run(40);
    align_req = 1'b1;
    cycle();
    align_req = 1'b0;
    chk("align_outs_low", 32'(clk_out[1:0]), 32'd0);
    run(70);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fsk_clock_divider.md
Name: fsk_clock_divider

Overview:
- Multi-channel, runtime-programmable clock divider for the FSK modulator clocking path.
- Produces N_CH divided, 50%-duty clock enables/strobes from the PLL clock.
- Each channel's ratio is reprogrammed through a valid/ready config port; new ratios take effect glitch-free at period boundaries.
- Per-channel and aggregate lock flags tell downstream tone generators when each output is stable.

Parameters:
- N_CH, 2, number of independent divider channels (1..16).
- CNT_W, 8, width of half-period value and counters.
- DEF_HALF, 8, reset half-period in clk cycles; f_out = f_clk/(2*half).
- LOCK_TOGGLES, 16, output toggles after reset or ratio change before lock asserts (1..2^CNT_W-1).

Ports:
- clk, input, 1: PLL output clock; all logic on its rising edge.
- pll_lock, input, 1: asynchronous active-low reset (PLL lock indicator); low clears all state.
- cfg_valid, input, 1: config request.
- cfg_ready, output, 1: config accept; combinational, equals !pend[cfg_ch].
- cfg_ch, input, CH_W = max(1, clog2(N_CH)): target channel.
- cfg_half, input, CNT_W: requested half-period.
- clk_out, output, N_CH: divided clocks.
- clk_lock, output, N_CH: per-channel lock, sticky.
- all_lock, output, 1: registered AND of clk_lock.

Behaviour:
- Reset (pll_lock=0, async):
  - Outputs: clk_out=0, clk_lock=0, all_lock=0.
  - Per channel: counter=0, half_active=DEF_HALF, pend=0, tog_cnt=0.
  - cfg_ready is driven 1 while in reset.
- Per channel, each cycle:
  - counter increments.
  - When counter == half_active-1: clk_out toggles, counter <= 0, tog_cnt increments, saturating at LOCK_TOGGLES.
  - First rising edge of clk_out occurs DEF_HALF cycles after reset release.
- Config handshake:
  - Transfer on cfg_valid & cfg_ready.
  - cfg_half=0 is clamped to 1; half=1 gives f_clk/2.
  - cfg_ch >= N_CH: accepted, no effect.
  - cfg_half equal to half_active while no pending value: accepted and dropped; lock is unaffected.
  - Otherwise the channel stores half_pend and sets pend; cfg_ready for that channel stays 0 until the update is applied.
- Ratio switch:
  - Applied only on the toggle cycle where clk_out goes 1->0 (end of a full period).
  - On that cycle: half_active <= half_pend, pend <= 0, tog_cnt <= 0, clk_lock <= 0.
  - Result: no runt pulse; the old ratio completes its current period.
- Lock:
  - clk_lock[i] sets the cycle after tog_cnt reaches LOCK_TOGGLES.
  - It clears only on reset or on an applied ratio change.
  - all_lock is registered, so it lags clk_lock by 1 cycle.
- Simultaneous events:
  - A config accept on the same cycle as a 1->0 toggle is not applied on that cycle; the new ratio waits for the next falling boundary.
  - Channels are fully independent; reconfiguring one channel never perturbs another.

Optional Feature:
- Macro: FSK_CLKDIV_PHASE_ALIGN_EN.
- With the macro defined:
  - Extra input port align_req (1 bit).
  - On the cycle align_req=1, every channel sets counter <= 0, clk_out <= 0 and applies any pending ratio.
  - Lock flags and tog_cnt are cleared.
  - All channels then restart phase-aligned; first rising edges occur half_active cycles later.
  - Config accepted on the same cycle as align_req is treated as pending, not applied.
- Without the macro: port absent; channels are free-running from reset.

Decomposition:
- Package fsk_clkdiv_pkg:
  - CNT_W default, DEF_HALF, LOCK_TOGGLES.
  - Half-period typedef (CNT_W-bit unsigned).
  - Clamp helper for zero half-periods.
- Sub-module fsk_clkdiv_channel (one per channel, generate loop):
  - Owns counter, half_active/half_pend/pend, toggle and lock logic.
- Top-level owns:
  - cfg decode and cfg_ready mux.
  - all_lock register.
  - align fan-out.

Test Plan:
- Reset release, defaults, 200 cycles -> both clk_out square at period 16 cycles, first rise at cycle 8; clk_lock sets after 16 toggles (cycle ~129); all_lock 1 cycle later.
- Write ch0 cfg_half=4 mid-high-phase -> cfg_ready[ch0]=0 until next falling edge; then period 8, no pulse shorter than 4 cycles; clk_lock[0] drops, re-asserts after 16 toggles; ch1 unchanged.
- Write cfg_half=0 -> clamps to 1: clk_out toggles every cycle; write cfg_half=8 while locked on 8 -> accepted, lock stays 1.
- Second write to ch0 while pend set -> cfg_ready=0, write stalls until applied; cfg_ch=3 with N_CH=2 -> accepted, no change.
- Drop pll_lock mid-period (async, between edges) -> all outputs 0 immediately; after release, behaviour matches first scenario with DEF_HALF restored.
- FSK_CLKDIV_PHASE_ALIGN_EN: ch0 half=3, ch1 half=5, pulse align_req -> both outputs 0, rising edges at +3 and +5 cycles, coincident every 30 cycles.
